// File: rtl/tile_scratchpad_pkg.sv
// tile_scratchpad shared types and default geometry.
// Row/shift helpers below describe the default build; modules recompute from their parameters.
package tile_scratchpad_pkg;

    localparam int DEF_BITWIDTH    = 16;
    localparam int DEF_ADDRWIDTH   = 16;
    localparam int DEF_TILEUNITS   = 4;
    localparam int DEF_DEPTH_TILES = 64;
    localparam int DEF_RD_CHANNELS = 3;
    localparam int DEF_WR_CHANNELS = 1;

    localparam int TILE_SHIFT = $clog2(DEF_TILEUNITS);
    localparam int ROW_W      = $clog2(DEF_DEPTH_TILES);

    typedef logic signed [DEF_TILEUNITS-1:0][DEF_BITWIDTH-1:0] tile_t;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

    function automatic int row_bits(int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/tile_scratchpad_if.sv
// tile_scratchpad bus: read request/response channels, write channels, status.
// master drives requests, slave is the scratchpad.
interface tile_scratchpad_if #(
    parameter int BITWIDTH    = 16,
    parameter int ADDRWIDTH   = 16,
    parameter int TILEUNITS   = 4,
    parameter int RD_CHANNELS = 3,
    parameter int WR_CHANNELS = 1
);

    logic [RD_CHANNELS-1:0]                               rd_req_valid;
    logic [RD_CHANNELS-1:0]                               rd_req_ready;
    logic [RD_CHANNELS-1:0][ADDRWIDTH-1:0]                rd_addr;
    logic [RD_CHANNELS-1:0]                               rd_rsp_valid;
    logic signed [RD_CHANNELS-1:0][TILEUNITS-1:0][BITWIDTH-1:0] rd_rsp_data;

    logic [WR_CHANNELS-1:0]                               wr_valid;
    logic [WR_CHANNELS-1:0]                               wr_ready;
    logic [WR_CHANNELS-1:0][ADDRWIDTH-1:0]                wr_addr;
    logic [WR_CHANNELS-1:0][TILEUNITS-1:0]                wr_mask;
    logic signed [WR_CHANNELS-1:0][TILEUNITS-1:0][BITWIDTH-1:0] wr_data;

    logic                                                 init_done;
    logic                                                 addr_err;

    modport master (
        output rd_req_valid, rd_addr,
        output wr_valid, wr_addr, wr_mask, wr_data,
        input  rd_req_ready, rd_rsp_valid, rd_rsp_data,
        input  wr_ready, init_done, addr_err
    );

    modport slave (
        input  rd_req_valid, rd_addr,
        input  wr_valid, wr_addr, wr_mask, wr_data,
        output rd_req_ready, rd_rsp_valid, rd_rsp_data,
        output wr_ready, init_done, addr_err
    );

endinterface

// File: rtl/tile_scratchpad_rd_port.sv
// One tile read channel: row decode, range check, two-register response.
// TILE_SCRATCHPAD_WR_BYPASS_EN merges same-cycle writes into the captured row.
module tile_scratchpad_rd_port
    import tile_scratchpad_pkg::*;
#(
    parameter int BITWIDTH    = DEF_BITWIDTH,
    parameter int ADDRWIDTH   = DEF_ADDRWIDTH,
    parameter int TILEUNITS   = DEF_TILEUNITS,
    parameter int DEPTH_TILES = DEF_DEPTH_TILES,
`ifdef TILE_SCRATCHPAD_WR_BYPASS_EN
    parameter int WR_CHANNELS = DEF_WR_CHANNELS,
`endif
    parameter int RW          = row_bits(DEF_DEPTH_TILES)
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                req_acc_i,
    input  logic [ADDRWIDTH-1:0]                addr_i,
    output logic [RW-1:0]                       row_o,
    input  logic [TILEUNITS-1:0][BITWIDTH-1:0]  row_data_i,
    output logic                                err_o,
`ifdef TILE_SCRATCHPAD_WR_BYPASS_EN
    input  logic [WR_CHANNELS-1:0]              wr_en_i,
    input  logic [WR_CHANNELS-1:0][RW-1:0]      wr_row_i,
    input  logic [WR_CHANNELS-1:0][TILEUNITS-1:0] wr_mask_i,
    input  logic [WR_CHANNELS-1:0][TILEUNITS-1:0][BITWIDTH-1:0] wr_data_i,
`endif
    output logic                                rsp_valid_o,
    output logic [TILEUNITS-1:0][BITWIDTH-1:0]  rsp_data_o
);

    localparam int SHIFT = $clog2(TILEUNITS);

    typedef logic [TILEUNITS-1:0][BITWIDTH-1:0] row_t;

    logic [ADDRWIDTH-1:0] row_full;
    logic                 in_range;
    row_t                 merged;

    logic s1_valid_q, s1_valid_d;
    row_t s1_data_q, s1_data_d;
    logic rsp_valid_q, rsp_valid_d;
    row_t rsp_data_q, rsp_data_d;

    assign row_full = addr_i >> SHIFT;
    assign in_range = row_full < ADDRWIDTH'(DEPTH_TILES);
    assign row_o    = row_full[RW-1:0];
    assign err_o    = req_acc_i & ~in_range;

`ifdef TILE_SCRATCHPAD_WR_BYPASS_EN
    // Ascending channel order so the highest writer wins each word.
    always_comb begin
        merged = row_data_i;
        for (int w = 0; w < WR_CHANNELS; w++) begin
            for (int u = 0; u < TILEUNITS; u++) begin
                if (wr_en_i[w] && (wr_row_i[w] == row_o) && wr_mask_i[w][u]) begin
                    merged[u] = wr_data_i[w][u];
                end
            end
        end
    end
`else
    assign merged = row_data_i;
`endif

    always_comb begin
        s1_valid_d  = req_acc_i;
        s1_data_d   = s1_data_q;
        rsp_valid_d = s1_valid_q;
        rsp_data_d  = rsp_data_q;
        if (req_acc_i) begin
            s1_data_d = in_range ? merged : '0;
        end
        if (s1_valid_q) begin
            rsp_data_d = s1_data_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;

endmodule

// File: rtl/tile_scratchpad.sv
// Tiled scratchpad top: memory array, row-by-row init engine, write arbitration.
// Define TILE_SCRATCHPAD_WR_BYPASS_EN for write-to-read bypass on same-row collisions.
module tile_scratchpad
    import tile_scratchpad_pkg::*;
#(
    parameter int BITWIDTH    = DEF_BITWIDTH,
    parameter int ADDRWIDTH   = DEF_ADDRWIDTH,
    parameter int TILEUNITS   = DEF_TILEUNITS,
    parameter int DEPTH_TILES = DEF_DEPTH_TILES,
    parameter int RD_CHANNELS = DEF_RD_CHANNELS,
    parameter int WR_CHANNELS = DEF_WR_CHANNELS
) (
    input  logic             clock,
    input  logic             reset,
    tile_scratchpad_if.slave bus
);

    localparam int SHIFT = $clog2(TILEUNITS);
    localparam int RW    = row_bits(DEPTH_TILES);

    typedef logic [TILEUNITS-1:0][BITWIDTH-1:0] row_t;

    state_e        state_q, state_d;
    logic [RW-1:0] init_ptr_q, init_ptr_d;
    logic          addr_err_q, addr_err_d;
    logic          ready;

    row_t mem_q [DEPTH_TILES];
    row_t mem_d [DEPTH_TILES];

    logic [RD_CHANNELS-1:0]          rd_acc;
    logic [RD_CHANNELS-1:0]          rd_err;
    logic [RD_CHANNELS-1:0][RW-1:0]  rd_row;
    row_t                            rd_row_data [RD_CHANNELS];
    logic [RD_CHANNELS-1:0]          rsp_valid;
    logic [RD_CHANNELS-1:0][TILEUNITS-1:0][BITWIDTH-1:0] rsp_data;

    logic [WR_CHANNELS-1:0]                wr_acc;
    logic [WR_CHANNELS-1:0]                wr_en;
    logic [WR_CHANNELS-1:0][ADDRWIDTH-1:0] wr_row_full;
    logic [WR_CHANNELS-1:0][RW-1:0]        wr_row;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= INIT;
            init_ptr_q <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
            addr_err_q <= addr_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        ready      = 1'b0;
        unique case (state_q)
            INIT: begin
                init_ptr_d = init_ptr_q + 1'b1;
                if (init_ptr_q == RW'(DEPTH_TILES - 1)) begin
                    state_d = READY;
                end
            end
            READY: begin
                ready = 1'b1;
            end
            default: begin
                state_d = INIT;
            end
        endcase
        addr_err_d = addr_err_q | (|rd_err) | (|(wr_acc & ~wr_en));
    end

    assign bus.rd_req_ready = {RD_CHANNELS{ready}};
    assign bus.wr_ready     = {WR_CHANNELS{ready}};
    assign bus.init_done    = ready;
    assign bus.addr_err     = addr_err_q;

    assign rd_acc = bus.rd_req_valid & {RD_CHANNELS{ready}};

    always_comb begin
        for (int w = 0; w < WR_CHANNELS; w++) begin
            wr_row_full[w] = bus.wr_addr[w] >> SHIFT;
            wr_row[w]      = wr_row_full[w][RW-1:0];
            wr_acc[w]      = bus.wr_valid[w] & ready;
            wr_en[w]       = wr_acc[w] & (wr_row_full[w] < ADDRWIDTH'(DEPTH_TILES));
        end
    end

    // Later channels overwrite earlier ones word by word.
    always_comb begin
        mem_d = mem_q;
        if (state_q == INIT) begin
            mem_d[init_ptr_q] = '0;
        end else begin
            for (int w = 0; w < WR_CHANNELS; w++) begin
                for (int u = 0; u < TILEUNITS; u++) begin
                    if (wr_en[w] && bus.wr_mask[w][u]) begin
                        mem_d[wr_row[w]][u] = bus.wr_data[w][u];
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    always_comb begin
        for (int r = 0; r < RD_CHANNELS; r++) begin
            rd_row_data[r] = mem_q[rd_row[r]];
        end
    end

    for (genvar r = 0; r < RD_CHANNELS; r++) begin : g_rd
        tile_scratchpad_rd_port #(
            .BITWIDTH    (BITWIDTH),
            .ADDRWIDTH   (ADDRWIDTH),
            .TILEUNITS   (TILEUNITS),
            .DEPTH_TILES (DEPTH_TILES),
`ifdef TILE_SCRATCHPAD_WR_BYPASS_EN
            .WR_CHANNELS (WR_CHANNELS),
`endif
            .RW          (RW)
        ) u_rd (
            .clock       (clock),
            .reset       (reset),
            .req_acc_i   (rd_acc[r]),
            .addr_i      (bus.rd_addr[r]),
            .row_o       (rd_row[r]),
            .row_data_i  (rd_row_data[r]),
            .err_o       (rd_err[r]),
`ifdef TILE_SCRATCHPAD_WR_BYPASS_EN
            .wr_en_i     (wr_en),
            .wr_row_i    (wr_row),
            .wr_mask_i   (bus.wr_mask),
            .wr_data_i   (bus.wr_data),
`endif
            .rsp_valid_o (rsp_valid[r]),
            .rsp_data_o  (rsp_data[r])
        );
    end

    assign bus.rd_rsp_valid = rsp_valid;
    assign bus.rd_rsp_data  = rsp_data;

endmodule

// File: tb/tb_tile_scratchpad.sv
// Scoreboard bench for tile_scratchpad with two write channels.
// Same-row read/write expectation follows TILE_SCRATCHPAD_WR_BYPASS_EN.
module tb_tile_scratchpad;
    import tile_scratchpad_pkg::*;

    localparam int BW = 16;
    localparam int AW = 16;
    localparam int TU = 4;
    localparam int DT = 64;
    localparam int RC = 3;
    localparam int WC = 2;

    typedef logic [TU-1:0][BW-1:0] tl_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    tl_t exp_q [RC][$];
    tl_t model [DT];

    tile_scratchpad_if #(
        .BITWIDTH(BW), .ADDRWIDTH(AW), .TILEUNITS(TU),
        .RD_CHANNELS(RC), .WR_CHANNELS(WC)
    ) bus ();

    tile_scratchpad #(
        .BITWIDTH(BW), .ADDRWIDTH(AW), .TILEUNITS(TU),
        .DEPTH_TILES(DT), .RD_CHANNELS(RC), .WR_CHANNELS(WC)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic tl_t mk(int a, int b, int c, int d);
        tl_t t;
        t[0] = BW'(a);
        t[1] = BW'(b);
        t[2] = BW'(c);
        t[3] = BW'(d);
        return t;
    endfunction

    task automatic idle();
        bus.rd_req_valid = '0;
        bus.wr_valid     = '0;
        bus.wr_mask      = '0;
    endtask

    task automatic rd(int ch, int addr, tl_t e);
        bus.rd_req_valid[ch] = 1'b1;
        bus.rd_addr[ch]      = AW'(addr);
        exp_q[ch].push_back(e);
    endtask

    task automatic wr(int ch, int addr, logic [TU-1:0] m, tl_t d);
        int row;
        bus.wr_valid[ch] = 1'b1;
        bus.wr_addr[ch]  = AW'(addr);
        bus.wr_mask[ch]  = m;
        bus.wr_data[ch]  = d;
        row = addr >> TILE_SHIFT;
        if (row < DT) begin
            for (int u = 0; u < TU; u++) if (m[u]) model[row][u] = d[u];
        end
    endtask

    task automatic clear_model();
        for (int c = 0; c < RC; c++) exp_q[c].delete();
        for (int r = 0; r < DT; r++) model[r] = '0;
    endtask

    task automatic test_reset();
        int n;
        int bad;
        reset = 1'b1;
        idle();
        repeat (2) @(negedge clock);
        tests++;
        if (bus.init_done !== 1'b0) begin
            fails++;
            $display("FAIL rst_init_done got %b want 0", bus.init_done);
        end
        tests++;
        if (bus.rd_req_ready !== 3'b000 || bus.wr_ready !== 2'b00) begin
            fails++;
            $display("FAIL rst_ready got %b/%b want 0/0", bus.rd_req_ready, bus.wr_ready);
        end
        tests++;
        if (bus.rd_rsp_valid !== 3'b000 || bus.rd_rsp_data !== '0) begin
            fails++;
            $display("FAIL rst_rsp got v=%b d=%h want 0", bus.rd_rsp_valid, bus.rd_rsp_data);
        end
        tests++;
        if (bus.addr_err !== 1'b0) begin
            fails++;
            $display("FAIL rst_addr_err got %b want 0", bus.addr_err);
        end
        reset = 1'b0;
        clear_model();
        bus.wr_valid[0]  = 1'b1;
        bus.wr_addr[0]   = AW'(48);
        bus.wr_mask[0]   = 4'b1111;
        bus.wr_data[0]   = mk(6, 6, 6, 6);
        bus.rd_req_valid = '1;
        bus.rd_addr[0]   = AW'(48);
        n = 0;
        bad = 0;
        while (!bus.init_done && n < 200) begin
            @(negedge clock);
            n++;
            if (!bus.init_done && (bus.rd_req_ready != 0 || bus.wr_ready != 0)) bad++;
            if (bus.rd_rsp_valid != 0) bad++;
        end
        idle();
        tests++;
        if (n !== 64) begin
            fails++;
            $display("FAIL init_len got %0d cycles want 64", n);
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL init_quiet got %0d bad cycles want 0", bad);
        end
        tests++;
        if (bus.rd_req_ready !== 3'b111 || bus.wr_ready !== 2'b11) begin
            fails++;
            $display("FAIL ready_up got %b/%b want 111/11", bus.rd_req_ready, bus.wr_ready);
        end
    endtask

    task automatic test_init_read();
        tl_t got;
        tl_t exp;
        rd(1, 40, '0);
        rd(2, 48, '0);
        @(negedge clock);
        idle();
        tests++;
        if (bus.rd_rsp_valid !== 3'b000) begin
            fails++;
            $display("FAIL init_rd_early got %b want 000", bus.rd_rsp_valid);
        end
        @(negedge clock);
        tests++;
        if (bus.rd_rsp_valid !== 3'b110) begin
            fails++;
            $display("FAIL init_rd_valid got %b want 110", bus.rd_rsp_valid);
        end
        for (int c = 0; c < RC; c++) if (bus.rd_rsp_valid[c] && exp_q[c].size() > 0) begin
            tests++;
            got = bus.rd_rsp_data[c];
            exp = exp_q[c].pop_front();
            if (got !== exp) begin
                fails++;
                $display("FAIL init_rd ch%0d got %h want %h", c, got, exp);
            end
        end
        @(negedge clock);
        tests++;
        if (bus.rd_rsp_valid !== 3'b000) begin
            fails++;
            $display("FAIL init_rd_pulse got %b want 000", bus.rd_rsp_valid);
        end
        for (int c = 0; c < RC; c++) begin
            tests++;
            if (exp_q[c].size() != 0) begin
                fails++;
                $display("FAIL init_rd_missing ch%0d got %0d left want 0", c, exp_q[c].size());
            end
        end
    endtask

    task automatic test_write_read();
        tl_t got;
        tl_t exp;
        wr(0, 'h28, 4'b1111, mk(1, -2, 3, -4));
        @(negedge clock);
        idle();
        rd(0, 'h2B, mk(1, -2, 3, -4));
        rd(2, 'h28, mk(1, -2, 3, -4));
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            idle();
            for (int c = 0; c < RC; c++) if (bus.rd_rsp_valid[c]) begin
                tests++;
                got = bus.rd_rsp_data[c];
                if (exp_q[c].size() == 0) begin
                    fails++;
                    $display("FAIL wr_rd ch%0d got extra %h want none", c, got);
                end else begin
                    exp = exp_q[c].pop_front();
                    if (got !== exp) begin
                        fails++;
                        $display("FAIL wr_rd ch%0d got %h want %h", c, got, exp);
                    end
                end
            end
        end
        for (int c = 0; c < RC; c++) begin
            tests++;
            if (exp_q[c].size() != 0) begin
                fails++;
                $display("FAIL wr_rd_missing ch%0d got %0d left want 0", c, exp_q[c].size());
            end
        end
    endtask

    task automatic test_mask_collision();
        tl_t got;
        tl_t exp;
        wr(0, 20, 4'b1111, mk(7, 7, 7, 7));
        wr(1, 21, 4'b0101, mk(9, 9, 9, 9));
        @(negedge clock);
        idle();
        wr(0, 20, 4'b0000, mk(5, 5, 5, 5));
        rd(1, 20, mk(9, 7, 9, 7));
        @(negedge clock);
        idle();
        rd(0, 22, mk(9, 7, 9, 7));
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            idle();
            for (int c = 0; c < RC; c++) if (bus.rd_rsp_valid[c]) begin
                tests++;
                got = bus.rd_rsp_data[c];
                if (exp_q[c].size() == 0) begin
                    fails++;
                    $display("FAIL collide ch%0d got extra %h want none", c, got);
                end else begin
                    exp = exp_q[c].pop_front();
                    if (got !== exp) begin
                        fails++;
                        $display("FAIL collide ch%0d got %h want %h", c, got, exp);
                    end
                end
            end
        end
        for (int c = 0; c < RC; c++) begin
            tests++;
            if (exp_q[c].size() != 0) begin
                fails++;
                $display("FAIL collide_missing ch%0d got %0d left want 0", c, exp_q[c].size());
            end
        end
    endtask

    task automatic test_same_cycle_rw();
        tl_t got;
        tl_t exp;
        wr(0, 12, 4'b1111, mk(1, 1, 1, 1));
        @(negedge clock);
        idle();
`ifdef TILE_SCRATCHPAD_WR_BYPASS_EN
        rd(1, 13, mk(2, 2, 2, 2));
`else
        rd(1, 13, mk(1, 1, 1, 1));
`endif
        wr(0, 12, 4'b1111, mk(2, 2, 2, 2));
        @(negedge clock);
        idle();
        rd(0, 12, mk(2, 2, 2, 2));
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            idle();
            for (int c = 0; c < RC; c++) if (bus.rd_rsp_valid[c]) begin
                tests++;
                got = bus.rd_rsp_data[c];
                if (exp_q[c].size() == 0) begin
                    fails++;
                    $display("FAIL same_rw ch%0d got extra %h want none", c, got);
                end else begin
                    exp = exp_q[c].pop_front();
                    if (got !== exp) begin
                        fails++;
                        $display("FAIL same_rw ch%0d got %h want %h", c, got, exp);
                    end
                end
            end
        end
        for (int c = 0; c < RC; c++) begin
            tests++;
            if (exp_q[c].size() != 0) begin
                fails++;
                $display("FAIL same_rw_missing ch%0d got %0d left want 0", c, exp_q[c].size());
            end
        end
    endtask

    task automatic test_out_of_range();
        tl_t got;
        tl_t exp;
        tests++;
        if (bus.addr_err !== 1'b0) begin
            fails++;
            $display("FAIL oor_pre got addr_err=%b want 0", bus.addr_err);
        end
        rd(0, 256, '0);
        wr(1, 280, 4'b1111, mk(8, 8, 8, 8));
        @(negedge clock);
        idle();
        rd(1, 24, '0);
        rd(2, 0, '0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            idle();
            for (int c = 0; c < RC; c++) if (bus.rd_rsp_valid[c]) begin
                tests++;
                got = bus.rd_rsp_data[c];
                if (exp_q[c].size() == 0) begin
                    fails++;
                    $display("FAIL oor ch%0d got extra %h want none", c, got);
                end else begin
                    exp = exp_q[c].pop_front();
                    if (got !== exp) begin
                        fails++;
                        $display("FAIL oor ch%0d got %h want %h", c, got, exp);
                    end
                end
            end
        end
        for (int c = 0; c < RC; c++) begin
            tests++;
            if (exp_q[c].size() != 0) begin
                fails++;
                $display("FAIL oor_missing ch%0d got %0d left want 0", c, exp_q[c].size());
            end
        end
        repeat (5) @(negedge clock);
        tests++;
        if (bus.addr_err !== 1'b1) begin
            fails++;
            $display("FAIL oor_sticky got addr_err=%b want 1", bus.addr_err);
        end
    endtask

    task automatic test_back_to_back();
        tl_t got;
        tl_t exp;
        tl_t last [RC];
        int  cnt [RC];
        int  row;
        for (int c = 0; c < RC; c++) begin
            cnt[c] = 0;
            last[c] = '0;
        end
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                for (int c = 0; c < RC; c++) begin
                    row = (i * 7 + c * 13) % 16;
                    rd(c, row * 4 + c, model[row]);
                end
            end
            @(negedge clock);
            idle();
            for (int c = 0; c < RC; c++) if (bus.rd_rsp_valid[c]) begin
                tests++;
                cnt[c]++;
                got = bus.rd_rsp_data[c];
                if (exp_q[c].size() == 0) begin
                    fails++;
                    $display("FAIL b2b ch%0d got extra %h want none", c, got);
                end else begin
                    exp = exp_q[c].pop_front();
                    last[c] = exp;
                    if (got !== exp) begin
                        fails++;
                        $display("FAIL b2b ch%0d got %h want %h", c, got, exp);
                    end
                end
            end
        end
        for (int c = 0; c < RC; c++) begin
            tests++;
            if (cnt[c] != 8) begin
                fails++;
                $display("FAIL b2b_count ch%0d got %0d want 8", c, cnt[c]);
            end
            tests++;
            if (bus.rd_rsp_data[c] !== last[c]) begin
                fails++;
                $display("FAIL b2b_hold ch%0d got %h want %h", c, bus.rd_rsp_data[c], last[c]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        tl_t got;
        tl_t exp;
        int  n;
        for (int i = 0; i < 3; i++) begin
            bus.rd_req_valid = '1;
            bus.rd_addr[0] = AW'(40);
            bus.rd_addr[1] = AW'(20);
            bus.rd_addr[2] = AW'(12);
            @(negedge clock);
        end
        reset = 1'b1;
        idle();
        @(negedge clock);
        tests++;
        if (bus.rd_rsp_valid !== 3'b000) begin
            fails++;
            $display("FAIL mid_rst_drop got %b want 000", bus.rd_rsp_valid);
        end
        reset = 1'b0;
        clear_model();
        n = 0;
        while (!bus.init_done && n < 200) begin
            @(negedge clock);
            n++;
        end
        tests++;
        if (n !== 64) begin
            fails++;
            $display("FAIL mid_rst_init got %0d cycles want 64", n);
        end
        tests++;
        if (bus.addr_err !== 1'b0) begin
            fails++;
            $display("FAIL mid_rst_err got %b want 0", bus.addr_err);
        end
        rd(0, 40, '0);
        rd(1, 20, '0);
        rd(2, 12, '0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            idle();
            for (int c = 0; c < RC; c++) if (bus.rd_rsp_valid[c]) begin
                tests++;
                got = bus.rd_rsp_data[c];
                if (exp_q[c].size() == 0) begin
                    fails++;
                    $display("FAIL mid_rst ch%0d got extra %h want none", c, got);
                end else begin
                    exp = exp_q[c].pop_front();
                    if (got !== exp) begin
                        fails++;
                        $display("FAIL mid_rst ch%0d got %h want %h", c, got, exp);
                    end
                end
            end
        end
        for (int c = 0; c < RC; c++) begin
            tests++;
            if (exp_q[c].size() != 0) begin
                fails++;
                $display("FAIL mid_rst_missing ch%0d got %0d left want 0", c, exp_q[c].size());
            end
        end
    endtask

    initial begin
        bus.rd_req_valid = '0;
        bus.rd_addr      = '0;
        bus.wr_valid     = '0;
        bus.wr_addr      = '0;
        bus.wr_mask      = '0;
        bus.wr_data      = '0;
        test_reset();
        test_init_read();
        test_write_read();
        test_mask_collision();
        test_same_cycle_rw();
        test_out_of_range();
        test_back_to_back();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tile_scratchpad.md
Name: tile_scratchpad

Overview:
- Parametrised tiled scratchpad: memory of DEPTH_TILES rows, each TILEUNITS signed words of BITWIDTH bits.
- Serves RD_CHANNELS independent tile-read channels (operand feeds A/D/B to the mesh) and WR_CHANNELS tile-write channels (C results from the mesh).
- Each read channel has a valid/ready request and a registered 1-cycle response.
- Writes support a per-word mask.
- After reset, a sequential init engine zeroes memory row by row; no single-cycle bulk clear.

Parameters:
- BITWIDTH, 16, word width in bits.
- ADDRWIDTH, 16, word-address width.
- TILEUNITS, 4, words per tile; power of two, at least 1.
- DEPTH_TILES, 64, number of rows; at least 2.
- RD_CHANNELS, 3, number of read channels.
- WR_CHANNELS, 1, number of write channels.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous reset, active-high
- rd_req_valid  in  1 [RD_CHANNELS]  read request valid
- rd_req_ready  out  1 [RD_CHANNELS]  read request ready
- rd_addr  in  ADDRWIDTH [RD_CHANNELS]  word address of requested tile
- rd_rsp_valid  out  1 [RD_CHANNELS]  response valid, one-cycle pulse
- rd_rsp_data  out  signed BITWIDTH [RD_CHANNELS][TILEUNITS]  tile data, word 0 = lowest address
- wr_valid  in  1 [WR_CHANNELS]  write request valid
- wr_ready  out  1 [WR_CHANNELS]  write ready
- wr_addr  in  ADDRWIDTH [WR_CHANNELS]  word address of target tile
- wr_mask  in  TILEUNITS [WR_CHANNELS]  per-word write enable
- wr_data  in  signed BITWIDTH [WR_CHANNELS][TILEUNITS]  write tile
- init_done  out  1  high when memory is usable
- addr_err  out  1  sticky out-of-range flag

Behaviour:
- Interface: clock is clock; reset is reset, synchronous, active-high.
- Reset values: state=INIT, init_ptr=0, init_done=0, addr_err=0, all rd_rsp_valid=0, all rd_rsp_data=0, all ready outputs=0.
- FSM states:
  - INIT: each cycle, row[init_ptr] <= 0 and init_ptr++. When init_ptr==DEPTH_TILES-1, go to READY next cycle. INIT lasts exactly DEPTH_TILES cycles after reset deasserts.
  - READY: terminal state. init_done=1; every rd_req_ready and wr_ready=1.
  - All ready outputs are 0 in INIT.
- Row decode: row = addr >> log2(TILEUNITS). Low address bits are ignored, so unaligned addresses hit their containing tile. Row >= DEPTH_TILES is out of range.
- Read timing: request accepted at edge N (valid && ready) -> rd_rsp_valid=1 and data valid after edge N+1, for one cycle.
  - rd_rsp_data holds its value until the next accepted response on that channel.
  - No response backpressure.
  - Back-to-back requests every cycle give one response per cycle.
- Out-of-range read: response is all zeros, rd_rsp_valid still pulses, addr_err<=1.
- Write: accepted at edge N (valid && ready); row words with mask bit set update at edge N. Mask all-zero is a legal no-op.
- Out-of-range write: dropped, addr_err<=1.
- Multi-writer collision (same row, same cycle): resolved per word; the highest-index channel with the mask bit set wins.
- Same-row read and write in the same cycle: read-first, response returns pre-write data (unless the Optional Feature is enabled).
- Multiple reads of the same row: all served; no conflicts.
- addr_err clears only on reset.
- Reset mid-operation: in-flight responses dropped (rd_rsp_valid=0 next cycle), FSM restarts INIT, memory re-zeroed.
- Requests presented during INIT are ignored.

Optional Feature:
- Macro: TILE_SCRATCHPAD_WR_BYPASS_EN.
- Defined: same-cycle same-row read returns post-write data. Masked words come from the winning writer; unmasked words come from the old row. The response is still at N+1.
- Undefined: read-first semantics as above.

Decomposition:
- Package tile_scratchpad_pkg:
  - state enum {INIT, READY};
  - localparams TILE_SHIFT=$clog2(TILEUNITS) and ROW_W=$clog2(DEPTH_TILES);
  - tile typedef helper for the BITWIDTH x TILEUNITS word array.
- Sub-module tile_scratchpad_rd_port, instantiated RD_CHANNELS times. Contains:
  - row decode and range check;
  - response data/valid registers;
  - bypass merge when the feature is enabled.
- Top level owns memory array, init FSM, write arbitration and addr_err.

Test Plan:
- Init: reset 1 cycle -> init_done=0 and readies=0 for 64 cycles, then init_done=1. A read of row 10 returns {0,0,0,0} one cycle after acceptance.
- Write/read: write addr 0x28, mask 4'b1111, data {1,-2,3,-4}; next cycle read addr 0x2B on ch0 and 0x28 on ch2 -> both return {1,-2,3,-4} with rd_rsp_valid one cycle later.
- Mask plus collision (WR_CHANNELS=2): ch0 writes row 5 {7,7,7,7} with mask 1111; ch1 writes {9,9,9,9} with mask 0101 in the same cycle -> row 5 reads {9,7,9,7} (word 0 first).
- Same-cycle read/write of row 3 (old {1,1,1,1}, new {2,2,2,2}) -> {1,1,1,1} without the macro, {2,2,2,2} with it.
- Out-of-range: read addr 256 (row 64) -> zeros, rd_rsp_valid=1, addr_err=1 and stays high. Write to row 70 leaves memory unchanged.
- Reset mid-stream: issue reads every cycle, assert reset while a response is pending -> rd_rsp_valid=0 next cycle, init repeats for 64 cycles, previously written rows read back zero.
